// File: rtl/gpioemu_host_seq.sv
// gpioemu_host_seq
// ----------------
// Host-side bus initiator for the gpioemu multiplier/popcount peripheral.
// It takes one job (A1, A2), writes both operands and the control register,
// polls status until it reads 2'b11 or gives up after POLL_MAX polls, then
// reads the product W and the ones count L and returns them on a result
// handshake.
//
// Every bus access has three phases:
//   SETUP  : 1 cycle, address/data valid, strobes low
//   STROBE : STROBE_CYC cycles, exactly one of srd/swr high
//   HOLD   : 1 cycle, strobes low, address held; read data captured here
//
// Ports:
//   clk, n_reset            clock, asynchronous active-low reset
//   job_valid/job_ready     job handshake, job_a1/job_a2 operands (24 bit)
//   res_valid/res_ready     result handshake
//   res_w, res_ones         product bits [31:0] and ones count
//   res_status              last polled status [1:0]
//   res_timeout             job gave up after POLL_MAX polls
//   saddress, srd, swr      peripheral address and strobes
//   sdata_out, sdata_in     peripheral write / read data
//   busy                    high whenever the sequencer is not idle
//   job_count               jobs completed without timeout (wraps)
//   dbg_state               {phase, state} for observation
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. job_ready is high only in IDLE, so a job is taken in IDLE and
// the sequencer leaves IDLE on that same edge. res_valid stays high, with
// res_* held stable, until the edge where res_ready is also high; the next
// job can only be accepted after that edge.

module gpioemu_host_seq #(
    parameter int STROBE_CYC = 2,
    parameter int POLL_GAP   = 4,
    parameter int POLL_MAX   = 64
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [23:0] job_a1,
    input  logic [23:0] job_a2,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_w,
    output logic [23:0] res_ones,
    output logic [1:0]  res_status,
    output logic        res_timeout,
    output logic [15:0] saddress,
    output logic        srd,
    output logic        swr,
    output logic [31:0] sdata_out,
    input  logic [31:0] sdata_in,
    output logic        busy,
    output logic [15:0] job_count,
    output logic [5:0]  dbg_state
);

    localparam logic [15:0] ADDR_A1   = 16'h0380;
    localparam logic [15:0] ADDR_A2   = 16'h0388;
    localparam logic [15:0] ADDR_W    = 16'h0390;
    localparam logic [15:0] ADDR_L    = 16'h0398;
    localparam logic [15:0] ADDR_CTRL = 16'h03A0;

    localparam int SCW = $clog2(STROBE_CYC + 1);
    localparam int GW  = $clog2(POLL_GAP + 2);
    localparam int PW  = $clog2(POLL_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_A1,
        S_WR_A2,
        S_WR_CTRL,
        S_POLL,
        S_GAP,
        S_RD_W,
        S_RD_L,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_STROBE,
        PH_HOLD
    } phase_t;

    state_t          state;
    phase_t          phase;
    logic [SCW-1:0]  stb_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [PW-1:0]   poll_cnt;
    // A1 goes straight onto sdata_out at accept, so only A2 needs holding.
    logic [23:0]     a2_q;
    logic            is_read;

    assign is_read   = (state == S_POLL) || (state == S_RD_W) || (state == S_RD_L);
    assign job_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign res_valid = (state == S_RESP);
    assign dbg_state = {phase, state};

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state       <= S_IDLE;
            phase       <= PH_SETUP;
            stb_cnt     <= '0;
            gap_cnt     <= '0;
            poll_cnt    <= '0;
            a2_q        <= '0;
            saddress    <= '0;
            sdata_out   <= '0;
            srd         <= 1'b0;
            swr         <= 1'b0;
            res_w       <= '0;
            res_ones    <= '0;
            res_status  <= '0;
            res_timeout <= 1'b0;
            job_count   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (job_valid) begin
                        a2_q        <= job_a2;
                        poll_cnt    <= '0;
                        res_w       <= '0;
                        res_ones    <= '0;
                        res_status  <= '0;
                        res_timeout <= 1'b0;
                        state       <= S_WR_A1;
                        phase       <= PH_SETUP;
                        saddress    <= ADDR_A1;
                        sdata_out   <= {8'h00, job_a1};
                    end
                end

                // Idle spacing between status polls; address stays on CTRL.
                S_GAP: begin
                    if (gap_cnt == GW'(POLL_GAP)) begin
                        state <= S_POLL;
                        phase <= PH_SETUP;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                S_RESP: begin
                    if (res_ready) begin
                        state <= S_IDLE;
                        if (!res_timeout) begin
                            job_count <= job_count + 16'd1;
                        end
                    end
                end

                // All remaining states are bus accesses sharing one phase engine.
                default: begin
                    case (phase)
                        PH_SETUP: begin
                            phase   <= PH_STROBE;
                            stb_cnt <= '0;
                            if (is_read) begin
                                srd <= 1'b1;
                            end else begin
                                swr <= 1'b1;
                            end
                        end

                        PH_STROBE: begin
                            if (stb_cnt == SCW'(STROBE_CYC - 1)) begin
                                phase <= PH_HOLD;
                                srd   <= 1'b0;
                                swr   <= 1'b0;
                            end else begin
                                stb_cnt <= stb_cnt + 1'b1;
                            end
                        end

                        PH_HOLD: begin
                            phase <= PH_SETUP;
                            case (state)
                                S_WR_A1: begin
                                    state     <= S_WR_A2;
                                    saddress  <= ADDR_A2;
                                    sdata_out <= {8'h00, a2_q};
                                end
                                S_WR_A2: begin
                                    state     <= S_WR_CTRL;
                                    saddress  <= ADDR_CTRL;
                                    sdata_out <= '0;
                                end
                                S_WR_CTRL: begin
                                    state     <= S_POLL;
                                    saddress  <= ADDR_CTRL;
                                    sdata_out <= '0;
                                end
                                S_POLL: begin
                                    res_status <= sdata_in[1:0];
                                    if (sdata_in[1:0] == 2'b11) begin
                                        state    <= S_RD_W;
                                        saddress <= ADDR_W;
                                    end else if (poll_cnt == PW'(POLL_MAX - 1)) begin
                                        // Last allowed poll still not done: abort
                                        // without touching W or L.
                                        poll_cnt    <= poll_cnt + 1'b1;
                                        state       <= S_RESP;
                                        res_timeout <= 1'b1;
                                        res_w       <= '0;
                                        res_ones    <= '0;
                                    end else begin
                                        poll_cnt <= poll_cnt + 1'b1;
                                        if (POLL_GAP == 0) begin
                                            state <= S_POLL;
                                        end else begin
                                            state   <= S_GAP;
                                            gap_cnt <= GW'(1);
                                        end
                                    end
                                end
                                S_RD_W: begin
                                    res_w    <= sdata_in;
                                    state    <= S_RD_L;
                                    saddress <= ADDR_L;
                                end
                                S_RD_L: begin
                                    res_ones <= sdata_in[23:0];
                                    state    <= S_RESP;
                                end
                                default: begin
                                    state <= S_IDLE;
                                end
                            endcase
                        end

                        default: begin
                            phase <= PH_SETUP;
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpioemu_host_seq.sv
// Testbench for gpioemu_host_seq: a small peripheral model answers the bus,
// a reference model predicts the bus transactions and results of every
// accepted job, and one compare process checks the DUT against it each cycle.

module tb_gpioemu_host_seq;

    localparam int STROBE_CYC = 2;
    localparam int POLL_GAP   = 4;
    localparam int POLL_MAX   = 4;
    // expected access entry: {is_write, addr[15:0], wdata[31:0], gap_before[7:0]}
    localparam int EW = 57;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    always #5 clk = ~clk;

    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [23:0] job_a1 = '0;
    logic [23:0] job_a2 = '0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] res_w;
    logic [23:0] res_ones;
    logic [1:0]  res_status;
    logic        res_timeout;
    logic [15:0] saddress;
    logic        srd;
    logic        swr;
    logic [31:0] sdata_out;
    logic [31:0] sdata_in = '0;
    logic        busy;
    logic [15:0] job_count;
    logic [5:0]  dbg_state;

    gpioemu_host_seq #(
        .STROBE_CYC(STROBE_CYC),
        .POLL_GAP  (POLL_GAP),
        .POLL_MAX  (POLL_MAX)
    ) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .job_valid  (job_valid),
        .job_ready  (job_ready),
        .job_a1     (job_a1),
        .job_a2     (job_a2),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_w      (res_w),
        .res_ones   (res_ones),
        .res_status (res_status),
        .res_timeout(res_timeout),
        .saddress   (saddress),
        .srd        (srd),
        .swr        (swr),
        .sdata_out  (sdata_out),
        .sdata_in   (sdata_in),
        .busy       (busy),
        .job_count  (job_count),
        .dbg_state  (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] prod32(input logic [23:0] a, input logic [23:0] b);
        logic [47:0] p;
        p = 48'(a) * 48'(b);
        return p[31:0];
    endfunction

    function automatic logic [23:0] ones32(input logic [31:0] v);
        logic [23:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) n = n + 24'(v[i]);
        return n;
    endfunction

    // ---------------- peripheral model ----------------
    // Status reads return 01 for the first cfg_ready_after polls after a
    // control write, 11 afterwards.
    int          cfg_ready_after = 0;
    int          slv_ready_after = 0;
    int          stat_idx = 0;
    int          rd_w_cnt = 0;
    logic [23:0] slv_a1 = '0;
    logic [23:0] slv_a2 = '0;
    logic        srd_q = 1'b0;
    logic        swr_q = 1'b0;

    always @(posedge clk) begin
        if (swr && !swr_q) begin
            case (saddress)
                16'h0380: slv_a1 <= sdata_out[23:0];
                16'h0388: slv_a2 <= sdata_out[23:0];
                16'h03A0: begin
                    stat_idx        <= 0;
                    slv_ready_after <= cfg_ready_after;
                end
                default: ;
            endcase
        end
        if (srd && !srd_q) begin
            case (saddress)
                16'h03A0: begin
                    sdata_in <= (stat_idx >= slv_ready_after) ? 32'h3 : 32'h1;
                    stat_idx <= stat_idx + 1;
                end
                16'h0390: begin
                    sdata_in <= prod32(slv_a1, slv_a2);
                    rd_w_cnt <= rd_w_cnt + 1;
                end
                16'h0398: sdata_in <= {8'h00, ones32(prod32(slv_a1, slv_a2))};
                default:  sdata_in <= 32'hDEAD_BEEF;
            endcase
        end
        srd_q <= srd;
        swr_q <= swr;
    end

    // ---------------- reference model + compare process ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] e;
    int            cyc = 0;
    int            acc_cyc = 0;
    int            exp_lat = 0;
    int            last_lat = 0;
    int            low_cnt = 0;
    int            hi_cnt = 0;
    int            n_polls = 0;
    logic          exp_to = 1'b0;
    logic [31:0]   exp_w = '0;
    logic [23:0]   exp_ones = '0;
    logic [1:0]    exp_status = '0;
    logic [15:0]   model_count = '0;
    logic          in_job = 1'b0;
    logic          res_seen = 1'b0;
    logic          prev_stb = 1'b0;
    logic          stb;
    logic [15:0]   prev_addr = '0;
    logic [31:0]   prev_data = '0;
    logic [15:0]   lat_addr = '0;
    logic [31:0]   lat_data = '0;

    task automatic push_acc(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                            input logic [7:0] gap);
        exp_q.push_back({wr, addr, data, gap});
    endtask

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!n_reset) begin
            prev_stb    = 1'b0;
            in_job      = 1'b0;
            res_seen    = 1'b0;
            model_count = '0;
            low_cnt     = 0;
            hi_cnt      = 0;
            prev_addr   = '0;
            prev_data   = '0;
        end else begin
            stb = srd | swr;
            chk("strobe_exclusive", srd & swr, 1'b0);

            if (stb && !prev_stb) begin
                chk("setup_addr", saddress, prev_addr);
                chk("setup_data", sdata_out, prev_data);
                chk("access_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("acc_is_write", swr, e[56]);
                    chk("acc_addr", saddress, e[55:40]);
                    if (e[56]) chk("acc_wdata", sdata_out, e[39:8]);
                    if (e[7:0] != 8'hFF) chk("acc_gap", low_cnt, e[7:0]);
                end
                lat_addr = saddress;
                lat_data = sdata_out;
                hi_cnt   = 1;
            end else if (stb) begin
                chk("strobe_addr_stable", saddress, lat_addr);
                chk("strobe_data_stable", sdata_out, lat_data);
                hi_cnt++;
            end

            if (!stb && prev_stb) begin
                chk("strobe_width", hi_cnt, STROBE_CYC);
                chk("hold_addr", saddress, lat_addr);
                low_cnt = 1;
            end else if (!stb) begin
                low_cnt++;
            end

            chk("busy", busy, in_job);
            chk("job_ready", job_ready, !in_job);
            chk("job_count", job_count, model_count);

            if (res_valid) begin
                chk("res_valid_in_job", in_job, 1'b1);
                if (!res_seen) begin
                    last_lat = cyc - acc_cyc;
                    chk("res_latency", last_lat, exp_lat);
                    chk("res_accesses_done", exp_q.size(), 0);
                    res_seen = 1'b1;
                end
                chk("res_w", res_w, exp_w);
                chk("res_ones", res_ones, exp_ones);
                chk("res_status", res_status, exp_status);
                chk("res_timeout", res_timeout, exp_to);
                if (res_ready) begin
                    if (!exp_to) model_count = model_count + 16'd1;
                    in_job = 1'b0;
                end
            end

            if (job_valid && job_ready) begin
                exp_to  = (cfg_ready_after >= POLL_MAX);
                n_polls = exp_to ? POLL_MAX : cfg_ready_after + 1;
                push_acc(1'b1, 16'h0380, {8'h00, job_a1}, 8'hFF);
                push_acc(1'b1, 16'h0388, {8'h00, job_a2}, 8'd2);
                push_acc(1'b1, 16'h03A0, 32'h0, 8'd2);
                for (int i = 0; i < n_polls; i++)
                    push_acc(1'b0, 16'h03A0, 32'h0, (i == 0) ? 8'd2 : 8'(POLL_GAP + 2));
                if (!exp_to) begin
                    push_acc(1'b0, 16'h0390, 32'h0, 8'd2);
                    push_acc(1'b0, 16'h0398, 32'h0, 8'd2);
                end
                exp_w      = exp_to ? 32'h0 : prod32(job_a1, job_a2);
                exp_ones   = exp_to ? 24'h0 : ones32(prod32(job_a1, job_a2));
                exp_status = exp_to ? 2'b01 : 2'b11;
                exp_lat    = (3 + n_polls + (exp_to ? 0 : 2)) * (STROBE_CYC + 2)
                             + (n_polls - 1) * POLL_GAP + 1;
                acc_cyc    = cyc;
                res_seen   = 1'b0;
                in_job     = 1'b1;
            end

            prev_stb  = stb;
            prev_addr = saddress;
            prev_data = sdata_out;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic offer_job(input logic [23:0] a1, input logic [23:0] a2, input int ready_after);
        logic ok;
        ok = 1'b0;
        cfg_ready_after = ready_after;
        @(posedge clk);
        #1;
        job_valid = 1'b1;
        job_a1    = a1;
        job_a2    = a2;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (job_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("job_accept_wait", ok, 1'b1);
        @(posedge clk);
        #1;
        job_valid = 1'b0;
    endtask

    // Returns just after the negedge preceding the result handshake edge.
    task automatic wait_result();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (res_valid && res_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("result_wait", ok, 1'b1);
        #1;
    endtask

    task automatic finish_handshake();
        @(posedge clk);
        #1;
    endtask

    int saved_rd_w;

    // ---------------- directed stimulus ----------------
    initial begin
        logic ok;
        #2;
        chk("rst_job_ready", job_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_strobes", {srd, swr}, 2'b00);
        chk("rst_saddress", saddress, 16'h0);
        chk("rst_sdata_out", sdata_out, 32'h0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res", {res_w, res_ones, res_status, res_timeout}, 59'h0);
        chk("rst_job_count", job_count, 16'h0);
        repeat (3) @(posedge clk);
        #2;
        n_reset = 1'b1;

        // 3 x 5, immediate completion
        offer_job(24'd3, 24'd5, 0);
        wait_result();
        chk("t1_res_w", res_w, 32'h0000_000F);
        chk("t1_res_ones", res_ones, 24'd4);
        chk("t1_res_status", res_status, 2'b11);
        chk("t1_latency", last_lat, 25);
        finish_handshake();
        chk("t1_job_count", job_count, 16'd1);

        // max operands
        offer_job(24'hFFFFFF, 24'hFFFFFF, 0);
        wait_result();
        chk("t2_res_w", res_w, 32'hFE00_0001);
        chk("t2_res_ones", res_ones, 24'd8);
        chk("t2_res_timeout", res_timeout, 1'b0);
        finish_handshake();

        // three busy polls then done
        offer_job(24'h001234, 24'h000056, 3);
        wait_result();
        chk("t3_status_reads", stat_idx, 4);
        chk("t3_res_status", res_status, 2'b11);
        finish_handshake();
        chk("t3_job_count", job_count, 16'd3);

        // status stuck at 01 -> timeout
        saved_rd_w = rd_w_cnt;
        offer_job(24'hABCDEF, 24'h000002, 100);
        wait_result();
        chk("t4_res_timeout", res_timeout, 1'b1);
        chk("t4_res_w", res_w, 32'h0);
        chk("t4_res_status", res_status, 2'b01);
        chk("t4_status_reads", stat_idx, 4);
        chk("t4_no_w_read", rd_w_cnt, saved_rd_w);
        finish_handshake();
        chk("t4_job_count", job_count, 16'd3);

        // consumer stalls 10 cycles; a second job waits for the handshake
        res_ready = 1'b0;
        offer_job(24'd7, 24'd9, 0);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t5_res_valid_wait", ok, 1'b1);
        @(posedge clk);
        #1;
        cfg_ready_after = 0;
        job_valid = 1'b1;
        job_a1    = 24'h123456;
        job_a2    = 24'h000010;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_hold_res_valid", res_valid, 1'b1);
            chk("t5_hold_job_ready", job_ready, 1'b0);
            chk("t5_hold_res_w", res_w, 32'h0000_003F);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (job_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t5_second_accept", ok, 1'b1);
        @(posedge clk);
        #1;
        job_valid = 1'b0;
        wait_result();
        chk("t5_second_res_w", res_w, 32'h0123_4560);
        finish_handshake();
        chk("t5_job_count", job_count, 16'd5);

        // reset during the A2 write strobe
        offer_job(24'h0000AA, 24'h0000BB, 0);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (swr && saddress == 16'h0388) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t6_reach_wr_a2", ok, 1'b1);
        #2;
        n_reset = 1'b0;
        #1;
        chk("t6_swr_dropped", swr, 1'b0);
        chk("t6_busy_dropped", busy, 1'b0);
        chk("t6_job_ready", job_ready, 1'b1);
        chk("t6_saddress", saddress, 16'h0);
        chk("t6_job_count", job_count, 16'h0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        #1;
        n_reset = 1'b1;
        offer_job(24'h000101, 24'h000101, 1);
        wait_result();
        chk("t6_fresh_res_w", res_w, 32'h0001_0201);
        chk("t6_fresh_res_ones", res_ones, 24'd3);
        finish_handshake();
        chk("t6_fresh_job_count", job_count, 16'd1);

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gpioemu_host_seq.md
Name: gpioemu_host_seq

Overview:
- Bus initiator that drives the gpioemu multiplier/popcount peripheral through its strobe bus (saddress/srd/swr/sdata).
- Accepts a job (A1, A2) on a valid/ready handshake, writes both operands, writes the control register, and polls status until completion.
- Then reads product W (0x0390) and ones-count L (0x0398) and returns them on a result handshake.
- Sits on the host side of the emulator, replacing software register pokes in system-level sims.

Parameters:
- STROBE_CYC, 2, clk cycles srd/swr held high per access (>=1).
- POLL_GAP, 4, idle cycles between consecutive status polls (>=0).
- POLL_MAX, 64, max status reads before timeout (>=1).

Ports:
- clk  input  1  system clock, all logic on rising edge
- n_reset  input  1  asynchronous active-low reset
- job_valid  input  1  job offered
- job_ready  output  1  sequencer can accept job
- job_a1  input  24  operand A1
- job_a2  input  24  operand A2
- res_valid  output  1  result available
- res_ready  input  1  result consumer ready
- res_w  output  32  product bits [31:0] read from 0x0390
- res_ones  output  24  ones count read from 0x0398 bits [23:0]
- res_status  output  2  last status value read from 0x03A0 bits [1:0]
- res_timeout  output  1  job aborted after POLL_MAX polls
- saddress  output  16  peripheral address
- srd  output  1  read strobe, peripheral samples on rising edge
- swr  output  1  write strobe, peripheral samples on rising edge
- sdata_out  output  32  write data to peripheral
- sdata_in  input  32  read data from peripheral
- busy  output  1  high whenever FSM not in IDLE
- job_count  output  16  jobs completed without timeout, wraps 0xFFFF->0

Behaviour:
- Reset (async, immediate): FSM=IDLE; srd=swr=0; saddress=0; sdata_out=0; res_* = 0; job_count=0; busy=0; job_ready=1. Reset mid-access drops strobes at once; no partial access completes.
- job_ready = (state==IDLE). Accept on job_valid&&job_ready; latch a1/a2; next cycle leaves IDLE.
- Bus access: SETUP 1 cycle (saddress and sdata_out valid, strobes 0), STROBE for STROBE_CYC cycles (the one strobe high, saddress/sdata_out stable), HOLD 1 cycle (strobes 0, address held). Read data is captured from sdata_in in HOLD. Access length = STROBE_CYC+2. srd and swr are never high together.
- Write data: sdata_out = {8'h0, operand}. Control write: sdata_out = 0, address 0x03A0.
- FSM: IDLE -> WR_A1 (0x0380) -> WR_A2 (0x0388) -> WR_CTRL (0x03A0 write) -> POLL (0x03A0 read).
  - POLL with status[1:0]==2'b11: go to RD_W.
  - POLL otherwise: poll_cnt+1, then GAP for POLL_GAP cycles, then POLL again.
  - poll_cnt reaches POLL_MAX without 2'b11: go to RESP with res_timeout=1, res_w=0, res_ones=0.
- Rest of sequence: RD_W (0x0390) -> RD_L (0x0398) -> RESP.
- poll_cnt clears on job accept. Any poll after the control write that returns 11 counts as completion, including the first poll.
- RESP: res_valid=1. Outputs stay stable until res_valid&&res_ready. On that cycle go to IDLE, res_valid falls next cycle. job_count increments on that handshake only if res_timeout==0.
- A new job is accepted no earlier than the cycle after the result handshake; no overlap.
- res_status holds the last polled status value; on timeout it is the last non-11 value.
- Between accesses saddress holds its last value and strobes stay 0.
- Nominal latency with STROBE_CYC=2 and one poll: 6 accesses x 4 cycles + 1 accept cycle = 25 cycles from accept to res_valid.

Test Plan:
- A1=3, A2=5, slave model completes immediately, res_ready=1 -> bus sequence writes 0x0380=3, 0x0388=5, 0x03A0, then reads 0x03A0, 0x0390, 0x0398. Result res_w=0x0000000F, res_ones=4, res_status=2'b11, job_count=1, res_valid after 25 cycles.
- A1=A2=0xFFFFFF -> res_w=0xFE000001, res_ones=8, no timeout.
- Slave returns status 01 for 3 polls then 11, POLL_GAP=4 -> exactly 4 reads of 0x03A0, 4 idle cycles between each pair, then the W and L reads.
- Slave status stuck at 01, POLL_MAX=4 -> 4 polls, no reads of 0x0390/0x0398, res_timeout=1, res_w=0, res_status=01, job_count unchanged.
- res_ready held low 10 cycles in RESP -> outputs stable, job_ready=0, second job_valid ignored until the handshake.
- n_reset low during STROBE of WR_A2 -> swr=0 and busy=0 immediately; after release a fresh job runs the full sequence from WR_A1.
- Protocol checkers throughout: srd&&swr never both high; saddress and sdata_out stable while either strobe is high.
